// File: rtl/data_mem_pkg.sv
// Shared encodings and types for the data memory unit.
package data_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } st_e;

  // Index k holds the memory byte at DAddr + k.
  typedef logic [3:0][7:0] lanes_t;

  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SZ_BYTE: size_bytes = 3'd1;
      SZ_HALF: size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: endianness, write byte-enables, read extraction and extension.
module mem_lane_align
  import data_mem_pkg::*;
#(
  parameter int unsigned BIG_ENDIAN = 1
) (
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  input  lanes_t      rd_lanes,
  output lanes_t      wr_lanes,
  output logic [3:0]  byte_en,
  output logic [31:0] rdata
);

  logic [15:0] half;
  logic [31:0] word;

  always_comb begin : p_align
    wr_lanes = '0;
    byte_en  = 4'b0000;
    rdata    = 32'h0;
    half     = 16'h0;
    word     = 32'h0;
    case (size)
      SZ_BYTE: begin
        wr_lanes[0] = wdata[7:0];
        byte_en     = 4'b0001;
        rdata       = {{24{sign_ext & rd_lanes[0][7]}}, rd_lanes[0]};
      end
      SZ_HALF: begin
        byte_en = 4'b0011;
        if (BIG_ENDIAN != 0) begin
          wr_lanes[0] = wdata[15:8];
          wr_lanes[1] = wdata[7:0];
          half        = {rd_lanes[0], rd_lanes[1]};
        end else begin
          wr_lanes[0] = wdata[7:0];
          wr_lanes[1] = wdata[15:8];
          half        = {rd_lanes[1], rd_lanes[0]};
        end
        rdata = {{16{sign_ext & half[15]}}, half};
      end
      SZ_WORD: begin
        byte_en = 4'b1111;
        if (BIG_ENDIAN != 0) begin
          wr_lanes = {wdata[7:0], wdata[15:8], wdata[23:16], wdata[31:24]};
          word     = {rd_lanes[0], rd_lanes[1], rd_lanes[2], rd_lanes[3]};
        end else begin
          wr_lanes = wdata;
          word     = rd_lanes;
        end
        rdata = word;
      end
      default: begin
        byte_en = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_unit.sv
// Single-outstanding byte-addressable data memory with programmable read latency.
module data_mem_unit
  import data_mem_pkg::*;
#(
  parameter int unsigned DEPTH_BYTES = 256,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned RD_LATENCY  = 1,
  parameter int unsigned BIG_ENDIAN  = 1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic              DataMemRW,
  input  logic [1:0]        ReqSize,
  input  logic              ReqSigned,
  input  logic [ADDR_W-1:0] DAddr,
  input  logic [31:0]       DataIn,
  output logic              RspValid,
  input  logic              RspReady,
  output logic [31:0]       DataOut,
  output logic              RspErr
);

  localparam int unsigned IDX_W = $clog2(DEPTH_BYTES);
  localparam int unsigned EXT_W = ADDR_W + 1;
  localparam int unsigned CNT_W = 2;

  if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
    $fatal(1, "data_mem_unit: RD_LATENCY must be in 1..4");
  end
  if (DEPTH_BYTES < 4 || (DEPTH_BYTES & (DEPTH_BYTES - 1)) != 0) begin : g_bad_depth
    $fatal(1, "data_mem_unit: DEPTH_BYTES must be a power of two >= 4");
  end
  if (ADDR_W < IDX_W) begin : g_bad_addr_w
    $fatal(1, "data_mem_unit: ADDR_W too narrow for DEPTH_BYTES");
  end

  // Zero at time 0 only; reset deliberately leaves contents alone.
  logic [7:0] mem [DEPTH_BYTES] = '{default: 8'h00};

  st_e              state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             ready_next, valid_next, err_next;
  logic [31:0]      data_next;

  logic             accept, req_err, wr_en;
  logic [IDX_W-1:0] idx;
  logic [EXT_W-1:0] end_addr;
  lanes_t           rd_lanes, wr_lanes;
  logic [3:0]       byte_en;
  logic [31:0]      rd_data;

  assign accept   = ReqValid & ReqReady;
  assign idx      = DAddr[IDX_W-1:0];
  assign end_addr = {1'b0, DAddr} + EXT_W'(size_bytes(ReqSize));
  assign wr_en    = accept & DataMemRW & ~req_err;

  // Size, alignment and range legality; range uses one extra bit so it cannot wrap.
  always_comb begin : p_err
    case (ReqSize)
      SZ_BYTE: req_err = 1'b0;
      SZ_HALF: req_err = DAddr[0];
      SZ_WORD: req_err = |DAddr[1:0];
      default: req_err = 1'b1;
    endcase
    if (end_addr > EXT_W'(DEPTH_BYTES)) req_err = 1'b1;
  end

  always_comb begin : p_rd_lanes
    rd_lanes = '0;
    for (int k = 0; k < 4; k++) rd_lanes[k] = mem[idx + IDX_W'(k)];
  end

  mem_lane_align #(
    .BIG_ENDIAN (BIG_ENDIAN)
  ) u_lane_align (
    .size     (ReqSize),
    .sign_ext (ReqSigned),
    .wdata    (DataIn),
    .rd_lanes (rd_lanes),
    .wr_lanes (wr_lanes),
    .byte_en  (byte_en),
    .rdata    (rd_data)
  );

  always_ff @(posedge CLK) begin : p_mem_wr
    if (wr_en) begin
      for (int k = 0; k < 4; k++) begin
        if (byte_en[k]) mem[idx + IDX_W'(k)] <= wr_lanes[k];
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin : p_state_reg
    if (!RST_N) begin
      state    <= IDLE;
      cnt      <= '0;
      ReqReady <= 1'b1;
      RspValid <= 1'b0;
      RspErr   <= 1'b0;
      DataOut  <= 32'h0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      ReqReady <= ready_next;
      RspValid <= valid_next;
      RspErr   <= err_next;
      DataOut  <= data_next;
    end
  end

  always_comb begin : p_next_state
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        cnt_next = '0;
        if (accept) state_next = (RD_LATENCY == 1) ? RESP : WAIT;
      end
      WAIT: begin
        if (cnt == CNT_W'(RD_LATENCY - 2)) begin
          state_next = RESP;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      RESP: begin
        if (RspReady) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Response payload is captured only at accept, so it holds under backpressure.
  always_comb begin : p_out_next
    ready_next = (state_next == IDLE);
    valid_next = (state_next == RESP);
    err_next   = RspErr;
    data_next  = DataOut;
    if (accept) begin
      err_next  = req_err;
      data_next = (DataMemRW || req_err) ? 32'h0 : rd_data;
    end
  end

endmodule

// File: tb/tb_data_mem_unit.sv
// Directed bench: big-endian latency-3 instance plus little-endian latency-1 instance.
module tb_data_mem_unit;
  import data_mem_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        rw        [2];
  logic [1:0]  size      [2];
  logic        sgn       [2];
  logic [31:0] addr      [2];
  logic [31:0] din       [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] dout      [2];
  logic        rsp_err   [2];

  int n_checks = 0;
  int n_fails  = 0;
  int last_lat = 0;

  data_mem_unit #(
    .DEPTH_BYTES (256),
    .ADDR_W      (32),
    .RD_LATENCY  (3),
    .BIG_ENDIAN  (1)
  ) u_dut_be (
    .CLK       (clk),
    .RST_N     (rst_n),
    .ReqValid  (req_valid[0]),
    .ReqReady  (req_ready[0]),
    .DataMemRW (rw[0]),
    .ReqSize   (size[0]),
    .ReqSigned (sgn[0]),
    .DAddr     (addr[0]),
    .DataIn    (din[0]),
    .RspValid  (rsp_valid[0]),
    .RspReady  (rsp_ready[0]),
    .DataOut   (dout[0]),
    .RspErr    (rsp_err[0])
  );

  data_mem_unit #(
    .DEPTH_BYTES (256),
    .ADDR_W      (32),
    .RD_LATENCY  (1),
    .BIG_ENDIAN  (0)
  ) u_dut_le (
    .CLK       (clk),
    .RST_N     (rst_n),
    .ReqValid  (req_valid[1]),
    .ReqReady  (req_ready[1]),
    .DataMemRW (rw[1]),
    .ReqSize   (size[1]),
    .ReqSigned (sgn[1]),
    .DAddr     (addr[1]),
    .DataIn    (din[1]),
    .RspValid  (rsp_valid[1]),
    .RspReady  (rsp_ready[1]),
    .DataOut   (dout[1]),
    .RspErr    (rsp_err[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One full handshake; hold > 0 keeps RspReady low that many cycles and checks stability.
  task automatic xact(input int s, input logic w, input logic [1:0] sz, input logic sg,
                      input logic [31:0] a, input logic [31:0] d, input int hold,
                      output logic [31:0] rd, output logic er, output int lat);
    int n;
    @(negedge clk);
    req_valid[s] = 1'b1;
    rw[s]        = w;
    size[s]      = sz;
    sgn[s]       = sg;
    addr[s]      = a;
    din[s]       = d;
    n = 0;
    while (req_ready[s] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (req_ready[s] !== 1'b1) check("req_ready_timeout", 32'(req_ready[s]), 32'd1);
    @(posedge clk);
    #1;
    req_valid[s] = 1'b0;
    rw[s]        = ~w;
    addr[s]      = ~a;
    din[s]       = ~d;
    lat = 1;
    while (rsp_valid[s] !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (rsp_valid[s] !== 1'b1) check("rsp_valid_timeout", 32'(rsp_valid[s]), 32'd1);
    rd = dout[s];
    er = rsp_err[s];
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check("bp_dout_stable", dout[s], rd);
      check("bp_req_ready_low", 32'(req_ready[s]), 32'd0);
      check("bp_rsp_valid_high", 32'(rsp_valid[s]), 32'd1);
    end
    rsp_ready[s] = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready[s] = 1'b0;
  endtask

  task automatic run(input int s, input logic w, input logic [1:0] sz, input logic sg,
                     input logic [31:0] a, input logic [31:0] d, input logic [31:0] exp_d,
                     input logic exp_e, input string tag);
    logic [31:0] rd;
    logic        er;
    xact(s, w, sz, sg, a, d, 0, rd, er, last_lat);
    check({tag, "_data"}, rd, exp_d);
    check({tag, "_err"}, 32'(er), 32'(exp_e));
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    rst_n = 1'b0;
    for (int s = 0; s < 2; s++) begin
      req_valid[s] = 1'b0;
      rw[s]        = 1'b0;
      size[s]      = SZ_BYTE;
      sgn[s]       = 1'b0;
      addr[s]      = 32'h0;
      din[s]       = 32'h0;
      rsp_ready[s] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    check("rst_dout", dout[0], 32'h0);
    check("rst_err", 32'(rsp_err[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_req_ready", 32'(req_ready[0]), 32'd1);

    // Big-endian word then sub-word reads
    run(0, 1'b1, SZ_WORD, 1'b0, 32'h10, 32'h11223344, 32'h0, 1'b0, "sw_10");
    check("lat3_write", 32'(last_lat), 32'd3);
    run(0, 1'b0, SZ_BYTE, 1'b0, 32'h10, 32'h0, 32'h00000011, 1'b0, "lb_10");
    run(0, 1'b0, SZ_BYTE, 1'b0, 32'h13, 32'h0, 32'h00000044, 1'b0, "lb_13");
    run(0, 1'b0, SZ_HALF, 1'b0, 32'h12, 32'h0, 32'h00003344, 1'b0, "lh_12");
    run(0, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'h11223344, 1'b0, "lw_10");
    check("lat3_read", 32'(last_lat), 32'd3);

    // Sign and zero extension
    run(0, 1'b1, SZ_BYTE, 1'b0, 32'h20, 32'hABCDEF80, 32'h0, 1'b0, "sb_20");
    run(0, 1'b0, SZ_BYTE, 1'b1, 32'h20, 32'h0, 32'hFFFFFF80, 1'b0, "lb_s_20");
    run(0, 1'b0, SZ_BYTE, 1'b0, 32'h20, 32'h0, 32'h00000080, 1'b0, "lbu_20");
    run(0, 1'b0, SZ_BYTE, 1'b0, 32'h21, 32'h0, 32'h00000000, 1'b0, "lbu_21");
    run(0, 1'b1, SZ_HALF, 1'b0, 32'h22, 32'h12348001, 32'h0, 1'b0, "sh_22");
    run(0, 1'b0, SZ_HALF, 1'b1, 32'h22, 32'h0, 32'hFFFF8001, 1'b0, "lh_s_22");
    run(0, 1'b0, SZ_HALF, 1'b0, 32'h22, 32'h0, 32'h00008001, 1'b0, "lhu_22");
    run(0, 1'b0, SZ_BYTE, 1'b0, 32'h23, 32'h0, 32'h00000001, 1'b0, "lbu_23");

    // Error cases and range boundaries
    run(0, 1'b1, SZ_WORD, 1'b0, 32'h02, 32'hDEADBEEF, 32'h0, 1'b1, "sw_mis_02");
    run(0, 1'b0, SZ_WORD, 1'b0, 32'h00, 32'h0, 32'h0, 1'b0, "lw_00_untouched");
    run(0, 1'b1, SZ_WORD, 1'b0, 32'h04, 32'hA5A5A5A5, 32'h0, 1'b0, "sw_04");
    run(0, 1'b0, SZ_HALF, 1'b0, 32'h05, 32'h0, 32'h0, 1'b1, "lh_mis_05");
    run(0, 1'b0, SZ_WORD, 1'b0, 32'hFE, 32'h0, 32'h0, 1'b1, "lw_fe");
    run(0, 1'b0, SZ_WORD, 1'b0, 32'h100, 32'h0, 32'h0, 1'b1, "lw_100_range");
    run(0, 1'b0, SZ_WORD, 1'b0, 32'hFFFFFFFC, 32'h0, 32'h0, 1'b1, "lw_wrap_range");
    run(0, 1'b1, SZ_WORD, 1'b0, 32'hFC, 32'hCAFEF00D, 32'h0, 1'b0, "sw_fc_edge");
    run(0, 1'b0, SZ_BYTE, 1'b0, 32'hFF, 32'h0, 32'h0000000D, 1'b0, "lb_ff_edge");
    run(0, 1'b0, SZ_ILL, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1, "ld_sz11");
    run(0, 1'b1, SZ_ILL, 1'b0, 32'h10, 32'hFFFFFFFF, 32'h0, 1'b1, "st_sz11");
    run(0, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'h11223344, 1'b0, "lw_10_after_err");

    // Backpressure: response held five cycles
    xact(0, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 5, rd, er, lat);
    check("bp_data", rd, 32'h11223344);
    check("bp_lat", 32'(lat), 32'd3);

    // Reset while a write sits in WAIT
    @(negedge clk);
    req_valid[0] = 1'b1;
    rw[0]        = 1'b1;
    size[0]      = SZ_WORD;
    addr[0]      = 32'h44;
    din[0]       = 32'h12345678;
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    rw[0]        = 1'b0;
    check("wait_rsp_valid_low", 32'(rsp_valid[0]), 32'd0);
    check("wait_req_ready_low", 32'(req_ready[0]), 32'd0);
    rst_n = 1'b0;
    #1;
    check("midrst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    check("midrst_dout", dout[0], 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midrst_req_ready", 32'(req_ready[0]), 32'd1);
    repeat (4) @(posedge clk);
    #1;
    check("midrst_no_resp", 32'(rsp_valid[0]), 32'd0);
    run(0, 1'b0, SZ_WORD, 1'b0, 32'h44, 32'h0, 32'h12345678, 1'b0, "lw_44_committed");

    // Little-endian instance with single-cycle latency
    run(1, 1'b1, SZ_WORD, 1'b0, 32'h00, 32'h11223344, 32'h0, 1'b0, "le_sw_00");
    check("lat1_write", 32'(last_lat), 32'd1);
    run(1, 1'b0, SZ_BYTE, 1'b0, 32'h00, 32'h0, 32'h00000044, 1'b0, "le_lb_00");
    run(1, 1'b0, SZ_HALF, 1'b0, 32'h02, 32'h0, 32'h00001122, 1'b0, "le_lh_02");
    run(1, 1'b0, SZ_WORD, 1'b0, 32'h00, 32'h0, 32'h11223344, 1'b0, "le_lw_00");
    run(1, 1'b1, SZ_HALF, 1'b0, 32'h04, 32'h00008001, 32'h0, 1'b0, "le_sh_04");
    run(1, 1'b0, SZ_HALF, 1'b1, 32'h04, 32'h0, 32'hFFFF8001, 1'b0, "le_lh_s_04");
    run(1, 1'b0, SZ_BYTE, 1'b0, 32'h04, 32'h0, 32'h00000001, 1'b0, "le_lb_04");
    check("lat1_read", 32'(last_lat), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
